exunit_alu: RTL and testbench

EXUNIT_ALU -- requirements
Module: exunit_alu

---
 rtl/exunit_alu.sv | 215 +++++++++++++++++++++
 tb/tb_exunit_alu.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exunit_alu.sv
`default_nettype none
// ============================================================================
// Module   : exunit_alu
// Purpose  : Single-issue integer execution unit with a valid/ready request
//            port and a valid/ready response port. Single-cycle ops return
//            their result one cycle after acceptance; the optional multiply
//            is an iterative shift-add taking WIDTH cycles in BUSY.
// Macro    : EXUNIT_ALU_MUL_EN - enables MUL (op 2). When undefined, op 2
//            is an undefined code and the BUSY state / multiply datapath
//            are not built.
// Ports    : clk        - rising-edge clock
//            reset_x    - synchronous active-low reset
//            req_valid  - request present
//            req_ready  - request accepted when high with req_valid
//            req_op     - 4-bit operation code
//            req_in1/2  - WIDTH-bit operands
//            req_tag    - TAG_W-bit opaque tag, returned with the result
//            resp_valid - result present
//            resp_ready - consumer accepts the result
//            resp_data  - WIDTH-bit result
//            resp_tag   - tag of the result
// Revision : 1.0 - initial release
// ============================================================================
module exunit_alu #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_x,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_in1,
    input  logic [WIDTH-1:0] req_in2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [TAG_W-1:0] resp_tag
);

    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SLL  = 4'd1;
    localparam logic [3:0] c_OP_XOR  = 4'd4;
    localparam logic [3:0] c_OP_SRL  = 4'd5;
    localparam logic [3:0] c_OP_OR   = 4'd6;
    localparam logic [3:0] c_OP_AND  = 4'd7;
    localparam logic [3:0] c_OP_SEQ  = 4'd8;
    localparam logic [3:0] c_OP_SNE  = 4'd9;
    localparam logic [3:0] c_OP_SUB  = 4'd10;
    localparam logic [3:0] c_OP_SRA  = 4'd11;
    localparam logic [3:0] c_OP_SLT  = 4'd12;
    localparam logic [3:0] c_OP_SGE  = 4'd13;
    localparam logic [3:0] c_OP_SLTU = 4'd14;
    localparam logic [3:0] c_OP_SGEU = 4'd15;

`ifdef EXUNIT_ALU_MUL_EN
    localparam logic [3:0]         c_OP_MUL   = 4'd2;
    localparam logic [SHAMT_W-1:0] c_CNT_LAST = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_HOLD = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd2
    } state_t;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_load_state;
    logic               w_accept;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]   r_resp_data;
    logic [TAG_W-1:0]   r_resp_tag;

`ifdef EXUNIT_ALU_MUL_EN
    logic               w_is_mul;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   w_acc_nxt;

    assign w_is_mul     = (req_op == c_OP_MUL);
    assign w_load_state = w_is_mul ? S_BUSY : S_HOLD;
    // One multiplier bit per cycle; the multiplicand walks left so only the
    // low WIDTH bits of the product are ever accumulated.
    assign w_acc_nxt    = r_acc + (r_mplier[0] ? r_mcand : '0);
`else
    assign w_load_state = S_HOLD;
`endif

    // reset_x gates req_ready so nothing is accepted while reset is asserted.
    assign req_ready  = reset_x & ((r_state == S_IDLE) |
                                   ((r_state == S_HOLD) & resp_ready));
    assign w_accept   = req_valid & req_ready;

    // Response outputs come only from registers: no path from req_* inputs.
    assign resp_valid = (r_state == S_HOLD);
    assign resp_data  = r_resp_data;
    assign resp_tag   = r_resp_tag;

    assign w_shamt    = req_in2[SHAMT_W-1:0];

    // Single-cycle result datapath
    always_comb begin
        w_result = '0;
        case (req_op)
            c_OP_ADD:  w_result = req_in1 + req_in2;
            c_OP_SUB:  w_result = req_in1 - req_in2;
            c_OP_SLL:  w_result = req_in1 << w_shamt;
            c_OP_SRL:  w_result = req_in1 >> w_shamt;
            c_OP_SRA:  w_result = $signed(req_in1) >>> w_shamt;
            c_OP_XOR:  w_result = req_in1 ^ req_in2;
            c_OP_OR:   w_result = req_in1 | req_in2;
            c_OP_AND:  w_result = req_in1 & req_in2;
            c_OP_SEQ:  w_result = {{(WIDTH-1){1'b0}}, (req_in1 == req_in2)};
            c_OP_SNE:  w_result = {{(WIDTH-1){1'b0}}, (req_in1 != req_in2)};
            c_OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(req_in1) <  $signed(req_in2))};
            c_OP_SGE:  w_result = {{(WIDTH-1){1'b0}}, ($signed(req_in1) >= $signed(req_in2))};
            c_OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, (req_in1 <  req_in2)};
            c_OP_SGEU: w_result = {{(WIDTH-1){1'b0}}, (req_in1 >= req_in2)};
            default:   w_result = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_load_state;
                end
            end
            S_HOLD: begin
                // A new accept in HOLD retires the old result in the same
                // cycle, so back-to-back single-cycle ops never bubble.
                if (w_accept) begin
                    w_state_nxt = w_load_state;
                end else if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef EXUNIT_ALU_MUL_EN
            S_BUSY: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_HOLD;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Result / tag registers and iterative multiplier
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            r_resp_data <= '0;
            r_resp_tag  <= '0;
`ifdef EXUNIT_ALU_MUL_EN
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_cnt       <= '0;
`endif
        end else begin
`ifdef EXUNIT_ALU_MUL_EN
            if (r_state == S_BUSY) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                if (r_cnt == c_CNT_LAST) begin
                    r_resp_data <= w_acc_nxt;
                end
            end
`endif
            if (w_accept) begin
                r_resp_tag <= req_tag;
`ifdef EXUNIT_ALU_MUL_EN
                if (w_is_mul) begin
                    r_acc    <= '0;
                    r_mcand  <= req_in1;
                    r_mplier <= req_in2;
                    r_cnt    <= '0;
                end else begin
                    r_resp_data <= w_result;
                end
`else
                r_resp_data <= w_result;
`endif
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exunit_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_exunit_alu
// Purpose  : Scoreboard bench for exunit_alu. A 32-bit and an 8-bit instance
//            share clock and reset. Stimulus pushes expected responses into
//            per-instance queues; monitors pop and compare on each response
//            handshake and check that stalled responses stay stable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exunit_alu;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_x;

    // 32-bit instance
    logic        a_valid, a_req_ready, a_resp_valid, a_resp_ready;
    logic [3:0]  a_op, a_tag, a_resp_tag;
    logic [31:0] a_in1, a_in2, a_resp_data;

    // 8-bit instance
    logic        b_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [3:0]  b_op, b_tag, b_resp_tag;
    logic [7:0]  b_in1, b_in2, b_resp_data;

    exunit_alu #(.WIDTH(32), .TAG_W(4)) u_dut32 (
        .clk        (clk),
        .reset_x    (reset_x),
        .req_valid  (a_valid),
        .req_ready  (a_req_ready),
        .req_op     (a_op),
        .req_in1    (a_in1),
        .req_in2    (a_in2),
        .req_tag    (a_tag),
        .resp_valid (a_resp_valid),
        .resp_ready (a_resp_ready),
        .resp_data  (a_resp_data),
        .resp_tag   (a_resp_tag)
    );

    exunit_alu #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk        (clk),
        .reset_x    (reset_x),
        .req_valid  (b_valid),
        .req_ready  (b_req_ready),
        .req_op     (b_op),
        .req_in1    (b_in1),
        .req_in2    (b_in2),
        .req_tag    (b_tag),
        .resp_valid (b_resp_valid),
        .resp_ready (b_resp_ready),
        .resp_data  (b_resp_data),
        .resp_tag   (b_resp_tag)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q32[$];
    exp_t q8[$];
    bit   rr_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference model: results computed from the operation definitions on
    // 64-bit values, then truncated to the operand width.
    function automatic logic [63:0] model(input int w, input logic [3:0] op,
                                          input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] mask, a, b, sa, sb, r;
        int sh;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a  = a_in & mask;
        b  = b_in & mask;
        sa = a[w-1] ? (a | ~mask) : a;
        sb = b[w-1] ? (b | ~mask) : b;
        sh = int'(b % 64'(w));
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a << sh;
`ifdef EXUNIT_ALU_MUL_EN
            4'd2:  r = a * b;
`endif
            4'd4:  r = a ^ b;
            4'd5:  r = a >> sh;
            4'd6:  r = a | b;
            4'd7:  r = a & b;
            4'd8:  r = 64'(a == b);
            4'd9:  r = 64'(a != b);
            4'd10: r = a - b;
            4'd11: r = $signed(sa) >>> sh;
            4'd12: r = 64'($signed(sa) <  $signed(sb));
            4'd13: r = 64'($signed(sa) >= $signed(sb));
            4'd14: r = 64'(a <  b);
            4'd15: r = 64'(a >= b);
            default: r = 64'd0;
        endcase
        return r & mask;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        if (rr_rand) begin
            a_resp_ready = ($urandom_range(0, 3) != 0);
            b_resp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic finish_now();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "bench aborted");
    endtask

    // Present a request at the current negedge and hold it until accepted.
    // Returns at the negedge following the accepting edge with valid still up.
    task automatic issue(input bit sel8, input logic [3:0] op, input logic [63:0] x,
                         input logic [63:0] y, input logic [3:0] tag, input bit use_exp,
                         input logic [63:0] expv, output int waits);
        exp_t e;
        if (sel8) begin
            b_op = op; b_in1 = x[7:0]; b_in2 = y[7:0]; b_tag = tag; b_valid = 1'b1;
        end else begin
            a_op = op; a_in1 = x[31:0]; a_in2 = y[31:0]; a_tag = tag; a_valid = 1'b1;
        end
        waits = 0;
        #2;
        while (!(sel8 ? b_req_ready : a_req_ready)) begin
            tick();
            #2;
            waits++;
            if (waits > 200) begin
                n_tests++;
                n_fail++;
                $display("FAIL issue timeout: req_ready 0 for %0d cycles, required 1", waits);
                finish_now();
            end
        end
        e.data = use_exp ? expv : model(sel8 ? 8 : 32, op, x, y);
        e.tag  = tag;
        if (sel8) q8.push_back(e);
        else      q32.push_back(e);
        tick();
    endtask

    // Monitor for the 32-bit instance
    logic        a_prev_stall = 1'b0;
    logic [31:0] a_prev_data;
    logic [3:0]  a_prev_tag;
    exp_t        a_e;
    always @(negedge clk) begin
        #3;
        if (!reset_x) begin
            a_prev_stall = 1'b0;
        end else begin
            if (a_prev_stall) begin
                check("hold32 valid", 64'(a_resp_valid), 64'd1);
                check("hold32 data", 64'(a_resp_data), 64'(a_prev_data));
                check("hold32 tag", 64'(a_resp_tag), 64'(a_prev_tag));
            end
            if (a_resp_valid && a_resp_ready) begin
                if (q32.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL resp32 unexpected: got data 0x%0h, required no response", a_resp_data);
                end else begin
                    a_e = q32.pop_front();
                    check("resp32 data", 64'(a_resp_data), a_e.data);
                    check("resp32 tag", 64'(a_resp_tag), 64'(a_e.tag));
                end
            end
            a_prev_stall = a_resp_valid && !a_resp_ready;
            a_prev_data  = a_resp_data;
            a_prev_tag   = a_resp_tag;
        end
    end

    // Monitor for the 8-bit instance
    logic       b_prev_stall = 1'b0;
    logic [7:0] b_prev_data;
    logic [3:0] b_prev_tag;
    exp_t       b_e;
    always @(negedge clk) begin
        #3;
        if (!reset_x) begin
            b_prev_stall = 1'b0;
        end else begin
            if (b_prev_stall) begin
                check("hold8 valid", 64'(b_resp_valid), 64'd1);
                check("hold8 data", 64'(b_resp_data), 64'(b_prev_data));
                check("hold8 tag", 64'(b_resp_tag), 64'(b_prev_tag));
            end
            if (b_resp_valid && b_resp_ready) begin
                if (q8.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL resp8 unexpected: got data 0x%0h, required no response", b_resp_data);
                end else begin
                    b_e = q8.pop_front();
                    check("resp8 data", 64'(b_resp_data), b_e.data);
                    check("resp8 tag", 64'(b_resp_tag), 64'(b_e.tag));
                end
            end
            b_prev_stall = b_resp_valid && !b_resp_ready;
            b_prev_data  = b_resp_data;
            b_prev_tag   = b_resp_tag;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        finish_now();
    end

    initial begin
        int w;
        int nbad;
        int ncnt;
        logic [3:0] op;

        reset_x = 1'b0;
        a_valid = 1'b0; a_op = '0; a_in1 = '0; a_in2 = '0; a_tag = '0; a_resp_ready = 1'b1;
        b_valid = 1'b0; b_op = '0; b_in1 = '0; b_in2 = '0; b_tag = '0; b_resp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("reset resp_valid", 64'(a_resp_valid), 64'd0);
        check("reset resp_data", 64'(a_resp_data), 64'd0);
        check("reset resp_tag", 64'(a_resp_tag), 64'd0);
        check("reset req_ready", 64'(a_req_ready), 64'd0);
        check("reset8 resp_valid", 64'(b_resp_valid), 64'd0);
        @(negedge clk);
        reset_x = 1'b1;
        #1;
        check("post-reset req_ready", 64'(a_req_ready), 64'd1);
        tick();

        // SUB 5-7, latency 1
        issue(1'b0, 4'd10, 64'd5, 64'd7, 4'd3, 1'b1, 64'hFFFF_FFFE, w);
        a_valid = 1'b0;
        #1;
        check("sub latency valid", 64'(a_resp_valid), 64'd1);
        check("sub data", 64'(a_resp_data), 64'hFFFF_FFFE);
        check("sub tag", 64'(a_resp_tag), 64'd3);
        tick();

        // SRA / SLTU / SLT back to back
        issue(1'b0, 4'd11, 64'h8000_0000, 64'h24, 4'd1, 1'b1, 64'hF800_0000, w);
        issue(1'b0, 4'd14, 64'h8000_0000, 64'h24, 4'd2, 1'b1, 64'd0, w);
        issue(1'b0, 4'd12, 64'h8000_0000, 64'h24, 4'd4, 1'b1, 64'd1, w);
        a_valid = 1'b0;
        repeat (2) tick();

        // Stall in HOLD, then new request with no bubble
        a_resp_ready = 1'b0;
        issue(1'b0, 4'd0, 64'd1, 64'd2, 4'd5, 1'b1, 64'd3, w);
        a_valid = 1'b0;
        repeat (3) begin
            #1;
            check("stall valid", 64'(a_resp_valid), 64'd1);
            check("stall data", 64'(a_resp_data), 64'd3);
            check("stall req_ready", 64'(a_req_ready), 64'd0);
            tick();
        end
        a_resp_ready = 1'b1;
        issue(1'b0, 4'd4, 64'hF0, 64'hFF, 4'd6, 1'b1, 64'h0F, w);
        check("xor accepted without wait", 64'(w), 64'd0);
        a_valid = 1'b0;
        #1;
        check("xor no bubble valid", 64'(a_resp_valid), 64'd1);
        check("xor data", 64'(a_resp_data), 64'h0F);
        tick();
        tick();

        // Reset while a result is held: it must be dropped
        a_resp_ready = 1'b0;
        issue(1'b0, 4'd0, 64'd10, 64'd20, 4'd9, 1'b0, 64'd0, w);
        a_valid = 1'b0;
        tick();
        reset_x = 1'b0;
        q32.delete();
        #1;
        check("reset req_ready low", 64'(a_req_ready), 64'd0);
        tick();
        reset_x = 1'b1;
        a_resp_ready = 1'b1;
        #1;
        check("hold reset dropped", 64'(a_resp_valid), 64'd0);
        check("hold reset req_ready", 64'(a_req_ready), 64'd1);
        tick();

`ifdef EXUNIT_ALU_MUL_EN
        // MUL latency and BUSY behaviour
        issue(1'b0, 4'd2, 64'hFFFF, 64'h1_0001, 4'd7, 1'b1, 64'hFFFF_FFFF, w);
        a_valid = 1'b0;
        nbad = 0;
        for (int k = 1; k <= 32; k++) begin
            #1;
            if (a_resp_valid || a_req_ready) nbad++;
            tick();
        end
        check("mul busy cycles with valid/ready", 64'(nbad), 64'd0);
        #1;
        check("mul valid at 33", 64'(a_resp_valid), 64'd1);
        check("mul data", 64'(a_resp_data), 64'hFFFF_FFFF);
        tick();

        // Reset in cycle 10 of a MUL
        issue(1'b0, 4'd2, 64'h1234_5678, 64'h9ABC_DEF0, 4'd8, 1'b0, 64'd0, w);
        a_valid = 1'b0;
        repeat (9) tick();
        reset_x = 1'b0;
        q32.delete();
        #1;
        check("mul reset req_ready low", 64'(a_req_ready), 64'd0);
        tick();
        reset_x = 1'b1;
        #1;
        check("mul reset req_ready", 64'(a_req_ready), 64'd1);
        check("mul reset valid", 64'(a_resp_valid), 64'd0);
        ncnt = 0;
        repeat (40) begin
            tick();
            #1;
            if (a_resp_valid) ncnt++;
        end
        check("mul reset no response", 64'(ncnt), 64'd0);
        tick();
`endif

        // WIDTH=8 directed
        issue(1'b1, 4'd1, 64'h01, 64'h0B, 4'd2, 1'b1, 64'h08, w);
        b_valid = 1'b0;
        #1;
        check("w8 sll data", 64'(b_resp_data), 64'h08);
        tick();
        issue(1'b1, 4'd3, 64'h5A, 64'h33, 4'd3, 1'b1, 64'd0, w);
        b_valid = 1'b0;
        #1;
        check("w8 op3 valid", 64'(b_resp_valid), 64'd1);
        check("w8 op3 data", 64'(b_resp_data), 64'd0);
        tick();

        // Randomized traffic, 32-bit
        rr_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            issue(1'b0, op, 64'(pick32()), 64'(pick32()), 4'($urandom_range(0, 15)), 1'b0, 64'd0, w);
            if ($urandom_range(0, 3) == 0) begin
                a_valid = 1'b0;
                tick();
            end
        end
        a_valid = 1'b0;

        // Randomized traffic, 8-bit
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            issue(1'b1, op, 64'($urandom_range(0, 255)), 64'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), 1'b0, 64'd0, w);
            if ($urandom_range(0, 3) == 0) begin
                b_valid = 1'b0;
                tick();
            end
        end
        b_valid = 1'b0;

        // Drain
        rr_rand = 1'b0;
        a_resp_ready = 1'b1;
        b_resp_ready = 1'b1;
        ncnt = 0;
        while ((q32.size() != 0 || q8.size() != 0) && ncnt < 200) begin
            tick();
            ncnt++;
        end
        check("drain q32 empty", 64'(q32.size()), 64'd0);
        check("drain q8 empty", 64'(q8.size()), 64'd0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
